// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer state type, default parameters and counter-width helper.
package rst_seq_pkg;
  typedef enum logic [1:0] {SYNC, HOLD, WAIT, DONE} state_t;
  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT = 255;
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: per-stage ack/reset handshake plus software re-sequence request.
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
);
  logic [NUM_STAGES-1:0] ack;
  logic                  sw_req;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  done;
  logic [NUM_STAGES-1:0] err;
  modport master(output ack, sw_req, input rst_out, done, err);
  modport slave(input ack, sw_req, output rst_out, done, err);
endinterface

// File: rtl/rst_sync.sv
// rst_sync: asynchronous-assert, synchronous-deassert reset flop chain.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_rst
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) r_chain <= '1;
    else r_chain <= {r_chain[STAGES-2:0], 1'b0};
  assign o_rst = r_chain[STAGES-1];
endmodule

// File: rtl/rst_seq.sv
// rst_seq: synchronised reset release, hold interval, then ack-gated per-stage release.
// Define RST_SEQ_TIMEOUT_EN to add per-stage ack timeouts with sticky err flags.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic     clk,
  input  logic     reset,
  rst_seq_if.slave io
);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam int HW = cnt_w(HOLD_CYCLES);
  if (NUM_STAGES < 1 || NUM_STAGES > 16 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_param_chk
    $error("rst_seq: parameter out of range");
  end
  logic                  w_sync, w_sw, w_ack, w_last, w_hold_end, w_adv, w_to;
  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [HW-1:0]         r_hcnt, w_hcnt_nxt;
  logic [NUM_STAGES-1:0] r_rst_out, w_rst_out_nxt;
  logic                  r_done, w_done_nxt;

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .i_rst(reset), .o_rst(w_sync));

  assign w_sw       = io.sw_req && r_state != SYNC;
  assign w_ack      = io.ack[r_idx];
  assign w_last     = r_idx == IW'(NUM_STAGES - 1);
  assign w_hold_end = r_hcnt >= HW'(HOLD_CYCLES - 1);
  assign w_adv      = r_state == WAIT && (w_ack || w_to);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= SYNC;
      r_idx     <= '0;
      r_hcnt    <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_done    <= w_done_nxt;
    end

  always_comb
    w_state_nxt = w_sw ? HOLD :
                  r_state == SYNC ? (w_sync ? SYNC : HOLD) :
                  r_state == HOLD ? (w_hold_end ? WAIT : HOLD) :
                  (w_adv && w_last) ? DONE : r_state;

  // Advancing stage i releases stage i+1; the last shift falls off the top.
  always_comb begin
    w_rst_out_nxt = w_sw ? '1 :
                    (r_state == HOLD && w_hold_end) ? r_rst_out & ~NUM_STAGES'(1) :
                    w_adv ? r_rst_out & ~(NUM_STAGES'(2) << r_idx) : r_rst_out;
    w_done_nxt    = !w_sw && (r_done || (w_adv && w_last));
    w_idx_nxt     = w_sw ? '0 : (w_adv && !w_last) ? r_idx + 1'b1 : r_idx;
    w_hcnt_nxt    = w_sw ? '0 : (r_state == HOLD && !w_hold_end) ? r_hcnt + 1'b1 : r_hcnt;
  end

  assign io.rst_out = r_rst_out;
  assign io.done    = r_done;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int TW = cnt_w(ACK_TIMEOUT);
  logic [TW-1:0]         r_tcnt;
  logic [NUM_STAGES-1:0] r_err;
  assign w_to = r_state == WAIT && !w_ack && r_tcnt >= TW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tcnt <= '0;
      r_err  <= '0;
    end else begin
      r_tcnt <= (w_sw || w_adv || r_state != WAIT) ? '0 : r_tcnt + TW'(r_tcnt < TW'(ACK_TIMEOUT));
      r_err  <= w_sw ? '0 : w_to ? r_err | (NUM_STAGES'(1) << r_idx) : r_err;
    end
  assign io.err = r_err;
`else
  assign w_to   = 1'b0;
  assign io.err = '0;
`endif
endmodule
